// File: rtl/tow_pkg.sv
// Constants shared by the tug-of-war controller and the player-side round judge.
package tow_pkg;

  localparam int NUM_LEDS_DEF = 9;

  localparam logic [1:0] LED_ALL   = 2'd0;
  localparam logic [1:0] LED_NONE  = 2'd1;
  localparam logic [1:0] LED_SCORE = 2'd3;

  localparam logic WIN_L = 1'b0;
  localparam logic WIN_R = 1'b1;

endpackage

// File: rtl/tow_btn_sync_edge.sv
// Synchronises one raw asynchronous button and emits a one-cycle pulse on its rising edge.
module tow_btn_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic press
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign press = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/tow_round_judge.sv
// Player-side round judge: button conditioning, round decision, rope position and LED bar.
module tow_round_judge
  import tow_pkg::*;
#(
  parameter int NUM_LEDS    = NUM_LEDS_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        btn_l,
  input  logic                        btn_r,
  input  logic                        leds_on,
  input  logic                        clear,
  input  logic                        clear_score,
  input  logic                        ready_clr,
  input  logic [1:0]                  leds_ctrl,
  output logic                        winrnd,
  output logic                        endrnd,
  output logic                        ready,
  output logic                        rnd_winner,
  output logic [$clog2(NUM_LEDS)-1:0] pos,
  output logic [NUM_LEDS-1:0]         leds
);

  localparam int            PW   = $clog2(NUM_LEDS);
  localparam logic [PW-1:0] HALF = PW'((NUM_LEDS - 1) / 2);
  localparam logic [PW-1:0] LAST = PW'(NUM_LEDS - 1);

  logic press_l;
  logic press_r;
  logic win_evt;
  logic winner;

  tow_btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_l (
    .clk   (clk),
    .rst   (rst),
    .din   (btn_l),
    .press (press_l)
  );

  tow_btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_r (
    .clk   (clk),
    .rst   (rst),
    .din   (btn_r),
    .press (press_r)
  );

  // In the dark phase a press is a false start and hands the round to the opponent.
  always_comb begin
    win_evt = 1'b0;
    winner  = WIN_L;
    if (!clear && !winrnd && (press_l ^ press_r)) begin
      win_evt = 1'b1;
      if (leds_on) winner = press_r ? WIN_R : WIN_L;
      else         winner = press_l ? WIN_R : WIN_L;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      winrnd     <= 1'b0;
      rnd_winner <= WIN_L;
      pos        <= HALF;
      ready      <= 1'b0;
      leds       <= '1;
    end else begin
      if (clear) begin
        winrnd <= 1'b0;
      end else if (win_evt) begin
        winrnd     <= 1'b1;
        rnd_winner <= winner;
      end

      // Recentring wins over a coincident round result.
      if (clear_score) begin
        pos <= HALF;
      end else if (win_evt) begin
        if (winner == WIN_L && pos != '0)   pos <= pos - 1'b1;
        if (winner == WIN_R && pos != LAST) pos <= pos + 1'b1;
      end

      if (ready_clr)             ready <= 1'b0;
      else if (press_l | press_r) ready <= 1'b1;

      case (leds_ctrl)
        LED_ALL:   leds <= '1;
        LED_SCORE: leds <= NUM_LEDS'(1) << pos;
        default:   leds <= '0;
      endcase
    end
  end

  assign endrnd = (pos == '0) | (pos == LAST);

endmodule

// File: tb/tb_tow_round_judge.sv
// Directed self-checking bench for tow_round_judge with the default 9-LED, 2-stage configuration.
module tb_tow_round_judge;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_l, btn_r;
  logic       leds_on, clear, clear_score, ready_clr;
  logic [1:0] leds_ctrl;
  logic       winrnd, endrnd, ready, rnd_winner;
  logic [3:0] pos;
  logic [8:0] leds;

  int vectors    = 0;
  int miscompares = 0;

  tow_round_judge #(.NUM_LEDS(9), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_l       (btn_l),
    .btn_r       (btn_r),
    .leds_on     (leds_on),
    .clear       (clear),
    .clear_score (clear_score),
    .ready_clr   (ready_clr),
    .leds_ctrl   (leds_ctrl),
    .winrnd      (winrnd),
    .endrnd      (endrnd),
    .ready       (ready),
    .rnd_winner  (rnd_winner),
    .pos         (pos),
    .leds        (leds)
  );

  always #5 clk = ~clk;

  // Advance n active edges; inputs change and outputs are sampled 1ns after each edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hold a button pattern long enough for one press pulse to reach the judge, then release.
  task automatic press(input logic l, input logic r);
    btn_l = l;
    btn_r = r;
    tick(3);
    btn_l = 1'b0;
    btn_r = 1'b0;
  endtask

  task automatic close_round();
    clear = 1'b1;
    tick(3);
    clear = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    btn_l = 1'b0; btn_r = 1'b0;
    leds_on = 1'b0; clear = 1'b1; clear_score = 1'b0; ready_clr = 1'b0;
    leds_ctrl = 2'd0;
    tick(3);
    rst = 1'b0;
    tick(2);

    // Reset state
    check_output("rst_leds",   leds,       9'h1FF);
    check_output("rst_pos",    pos,        4);
    check_output("rst_winrnd", winrnd,     0);
    check_output("rst_endrnd", endrnd,     0);
    check_output("rst_ready",  ready,      0);
    check_output("rst_winner", rnd_winner, 0);

    // Valid right win in the lit phase, latency SYNC_STAGES+1 edges
    clear = 1'b0; leds_on = 1'b1;
    btn_r = 1'b1;
    tick(1); check_output("lat_e1_winrnd", winrnd, 0);
    tick(1); check_output("lat_e2_winrnd", winrnd, 0);
    tick(1); check_output("lat_e3_winrnd", winrnd, 1);
    check_output("r_win_pos",    pos,        5);
    check_output("r_win_winner", rnd_winner, 1);
    tick(1);
    btn_r = 1'b0;
    tick(3);
    press(1'b0, 1'b1);
    tick(2);
    check_output("second_press_pos",    pos,    5);
    check_output("second_press_winrnd", winrnd, 1);
    leds_ctrl = 2'd3;
    tick(1);
    check_output("score_leds", leds, 9'h020);
    leds_ctrl = 2'd1;
    tick(1);
    check_output("none_leds", leds, 9'h000);
    leds_ctrl = 2'd2;
    tick(1);
    check_output("reserved_leds", leds, 9'h000);
    leds_ctrl = 2'd0;
    clear = 1'b1;
    tick(1);
    check_output("clear_winrnd", winrnd,     0);
    check_output("clear_winner", rnd_winner, 1);

    // False start by left player in the dark phase
    clear_score = 1'b1;
    tick(1);
    clear_score = 1'b0;
    check_output("recentre_pos", pos, 4);
    tick(2);
    clear = 1'b0; leds_on = 1'b0;
    press(1'b1, 1'b0);
    check_output("fs_winrnd", winrnd,     1);
    check_output("fs_winner", rnd_winner, 1);
    check_output("fs_pos",    pos,        5);
    close_round();
    press(1'b1, 1'b1);
    tick(2);
    check_output("both_winrnd", winrnd, 0);
    check_output("both_pos",    pos,    5);

    // Left wins walk the rope to the left end and saturate
    clear = 1'b1; clear_score = 1'b1;
    tick(1);
    clear_score = 1'b0;
    tick(2);
    clear = 1'b0; leds_on = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      press(1'b1, 1'b0);
      check_output("walk_winrnd", winrnd,     1);
      check_output("walk_winner", rnd_winner, 0);
      check_output("walk_pos",    pos,        (k >= 4) ? 0 : 4 - k);
      check_output("walk_endrnd", endrnd,     (k >= 4) ? 1 : 0);
      close_round();
    end

    // Ready handshake and recentre priority
    clear = 1'b1;
    ready_clr = 1'b1;
    tick(1);
    check_output("ready_cleared", ready, 0);
    ready_clr = 1'b0;
    press(1'b1, 1'b0);
    check_output("ready_set",     ready,  1);
    check_output("ready_no_win",  winrnd, 0);
    ready_clr = 1'b1;
    tick(1);
    check_output("ready_clr", ready, 0);
    tick(2);
    clear = 1'b0; leds_on = 1'b1;
    btn_r = 1'b1;
    tick(2);
    clear_score = 1'b1;
    tick(1);
    clear_score = 1'b0;
    btn_r = 1'b0;
    check_output("cs_win_winrnd", winrnd, 1);
    check_output("cs_win_pos",    pos,    4);
    check_output("cs_ready_prio", ready,  0);
    ready_clr = 1'b0;
    close_round();

    // Reach pos=2 with winrnd=1, then reset mid-window
    press(1'b1, 1'b0);
    close_round();
    leds_ctrl = 2'd3;
    press(1'b1, 1'b0);
    tick(1);
    check_output("pre_rst_pos",    pos,    2);
    check_output("pre_rst_winrnd", winrnd, 1);
    check_output("pre_rst_leds",   leds,   9'h004);
    check_output("pre_rst_ready",  ready,  1);
    btn_l = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check_output("async_rst_winrnd", winrnd,     0);
    check_output("async_rst_pos",    pos,        4);
    check_output("async_rst_leds",   leds,       9'h1FF);
    check_output("async_rst_ready",  ready,      0);
    check_output("async_rst_winner", rnd_winner, 0);
    check_output("async_rst_endrnd", endrnd,     0);
    tick(2);
    btn_l = 1'b0;
    clear = 1'b1;
    leds_ctrl = 2'd0;
    rst = 1'b0;
    tick(4);
    check_output("post_rst_winrnd", winrnd, 0);
    check_output("post_rst_pos",    pos,    4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
